// File: rtl/glb_cgra_cfg_bridge.sv
// Per-PRR configuration bridge: retimes GLB config writes/reads toward one PRR,
// returns latency-matched read data, flags read/write collisions and counts writes.
module glb_cgra_cfg_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int PIPE_DEPTH = 2,
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  glb_cfg_wr_en,
   input  logic                  glb_cfg_rd_en,
   input  logic [ADDR_WIDTH-1:0] glb_cfg_addr,
   input  logic [DATA_WIDTH-1:0] glb_cfg_wr_data,
   output logic [DATA_WIDTH-1:0] glb_cfg_rd_data,
   output logic                  glb_cfg_rd_data_valid,
   output logic                  glb_cfg_busy,
   output logic                  cgra_cfg_wr_en,
   output logic [ADDR_WIDTH-1:0] cgra_cfg_wr_addr,
   output logic [DATA_WIDTH-1:0] cgra_cfg_wr_data,
   output logic                  cgra_cfg_rd_en,
   output logic [ADDR_WIDTH-1:0] cgra_cfg_rd_addr,
   input  logic [DATA_WIDTH-1:0] cgra_cfg_rd_data,
   input  logic                  err_clr,
   output logic                  err_collision,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   localparam int TAG_LEN = PIPE_DEPTH + RD_LATENCY;

   logic                  req_wr, req_rd, collision;
   logic [PIPE_DEPTH:0]   wr_in, rd_in;
   logic [TAG_LEN:0]      tag_in;
   logic [ADDR_WIDTH-1:0] addr_in [PIPE_DEPTH+1];
   logic [DATA_WIDTH-1:0] data_in [PIPE_DEPTH+1];

   logic [PIPE_DEPTH-1:0] wr_v_d, wr_v_q;
   logic [PIPE_DEPTH-1:0] rd_v_d, rd_v_q;
   logic [ADDR_WIDTH-1:0] addr_d [PIPE_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [PIPE_DEPTH];
   logic [DATA_WIDTH-1:0] data_d [PIPE_DEPTH];
   logic [DATA_WIDTH-1:0] data_q [PIPE_DEPTH];
   logic [TAG_LEN-1:0]    tag_d, tag_q;
   logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
   logic                  rd_valid_d, rd_valid_q;
   logic                  busy_d, busy_q;
   logic                  err_d, err_q;
   logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;

   // A simultaneous read and write is illegal; both are dropped.
   always_comb begin
      req_wr    = glb_cfg_wr_en & ~glb_cfg_rd_en;
      req_rd    = glb_cfg_rd_en & ~glb_cfg_wr_en;
      collision = glb_cfg_wr_en & glb_cfg_rd_en;

      wr_in      = {wr_v_q, req_wr};
      rd_in      = {rd_v_q, req_rd};
      tag_in     = {tag_q, req_rd};
      addr_in[0] = glb_cfg_addr;
      data_in[0] = glb_cfg_wr_data;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         addr_in[i+1] = addr_q[i];
         data_in[i+1] = data_q[i];
      end

      wr_v_d = wr_in[PIPE_DEPTH-1:0];
      rd_v_d = rd_in[PIPE_DEPTH-1:0];
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         addr_d[i] = (wr_in[i] | rd_in[i]) ? addr_in[i] : addr_q[i];
         data_d[i] = wr_in[i] ? data_in[i] : data_q[i];
      end

      tag_d      = tag_in[TAG_LEN-1:0];
      busy_d     = |tag_d;
      rd_valid_d = tag_q[TAG_LEN-1];
      rd_data_d  = tag_q[TAG_LEN-1] ? cgra_cfg_rd_data : rd_data_q;

      if (collision)
         err_d = 1'b1;
      else if (err_clr)
         err_d = 1'b0;
      else
         err_d = err_q;

      cnt_d = cnt_q;
      if (wr_v_q[PIPE_DEPTH-1] && (cnt_q != {CNT_WIDTH{1'b1}}))
         cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_v_q     <= '0;
         rd_v_q     <= '0;
         tag_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_v_q     <= wr_v_d;
         rd_v_q     <= rd_v_d;
         tag_q      <= tag_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign cgra_cfg_wr_en        = wr_v_q[PIPE_DEPTH-1];
   assign cgra_cfg_wr_addr      = addr_q[PIPE_DEPTH-1];
   assign cgra_cfg_wr_data      = data_q[PIPE_DEPTH-1];
   assign cgra_cfg_rd_en        = rd_v_q[PIPE_DEPTH-1];
   assign cgra_cfg_rd_addr      = addr_q[PIPE_DEPTH-1];
   assign glb_cfg_rd_data       = rd_data_q;
   assign glb_cfg_rd_data_valid = rd_valid_q;
   assign glb_cfg_busy          = busy_q;
   assign err_collision         = err_q;
   assign wr_count              = cnt_q;

endmodule

// File: tb/tb_glb_cgra_cfg_bridge.sv
// Bench for glb_cgra_cfg_bridge: directed scenarios then random traffic, compared
// against a per-cycle event schedule derived from request timing rules.
module tb_glb_cgra_cfg_bridge;

   localparam int P = 2;
   localparam int R = 1;
   localparam int L = P + R;
   localparam int N = 2048;
   localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        glbWrEn, glbRdEn, errClr;
   logic [31:0] glbAddr, glbWrData;
   logic [31:0] glbRdData, cgraWrAddr, cgraWrData, cgraRdAddr, cgraRdData;
   logic        glbRdValid, glbBusy, cgraWrEn, cgraRdEn, errCollision;
   logic [15:0] wrCount;

   logic [31:0] glbRdData4, cgraWrAddr4, cgraWrData4, cgraRdAddr4;
   logic        glbRdValid4, glbBusy4, cgraWrEn4, cgraRdEn4, errCollision4;
   logic [3:0]  wrCount4;

   logic [31:0] prrData;

   int testCount = 0;
   int failCount = 0;
   int cyc = 0;

   bit          eWr [N];
   logic [31:0] eWa [N];
   logic [31:0] eWd [N];
   bit          eRd [N];
   logic [31:0] eRa [N];
   bit          eVal [N];
   logic [31:0] eDat [N];
   int          eBusy [N];

   logic [31:0] expRdata = '0;
   logic        expErr = 1'b0;
   int          expCnt = 0;
   int          expCnt4 = 0;

   always #5 clk = ~clk;

   // PRR model: answers addr ^ MAGIC one cycle after its read enable.
   always @(posedge clk)
      if (cgraRdEn) prrData <= cgraRdAddr ^ MAGIC;
   assign cgraRdData = prrData;

   glb_cgra_cfg_bridge #(.PIPE_DEPTH(P), .RD_LATENCY(R)) dut (
      .clk(clk), .reset(reset),
      .glb_cfg_wr_en(glbWrEn), .glb_cfg_rd_en(glbRdEn),
      .glb_cfg_addr(glbAddr), .glb_cfg_wr_data(glbWrData),
      .glb_cfg_rd_data(glbRdData), .glb_cfg_rd_data_valid(glbRdValid),
      .glb_cfg_busy(glbBusy),
      .cgra_cfg_wr_en(cgraWrEn), .cgra_cfg_wr_addr(cgraWrAddr),
      .cgra_cfg_wr_data(cgraWrData), .cgra_cfg_rd_en(cgraRdEn),
      .cgra_cfg_rd_addr(cgraRdAddr), .cgra_cfg_rd_data(cgraRdData),
      .err_clr(errClr), .err_collision(errCollision), .wr_count(wrCount)
   );

   glb_cgra_cfg_bridge #(.PIPE_DEPTH(P), .RD_LATENCY(R), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .glb_cfg_wr_en(glbWrEn), .glb_cfg_rd_en(glbRdEn),
      .glb_cfg_addr(glbAddr), .glb_cfg_wr_data(glbWrData),
      .glb_cfg_rd_data(glbRdData4), .glb_cfg_rd_data_valid(glbRdValid4),
      .glb_cfg_busy(glbBusy4),
      .cgra_cfg_wr_en(cgraWrEn4), .cgra_cfg_wr_addr(cgraWrAddr4),
      .cgra_cfg_wr_data(cgraWrData4), .cgra_cfg_rd_en(cgraRdEn4),
      .cgra_cfg_rd_addr(cgraRdAddr4), .cgra_cfg_rd_data(cgraRdData),
      .err_clr(errClr), .err_collision(errCollision4), .wr_count(wrCount4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs mid-cycle, then advance the model.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] data, input logic clr, input logic rst);
      glbWrEn = wr; glbRdEn = rd; glbAddr = addr; glbWrData = data;
      errClr = clr; reset = rst;
      @(negedge clk);
      if (cyc + L + 3 >= N) $fatal(1, "[TB] FAIL schedule overflow cycle=%0d", cyc);
      if (eVal[cyc]) expRdata = eDat[cyc];
      checkOutput("cgra_wr_en", {31'd0, cgraWrEn}, {31'd0, eWr[cyc]});
      if (eWr[cyc]) begin
         checkOutput("cgra_wr_addr", cgraWrAddr, eWa[cyc]);
         checkOutput("cgra_wr_data", cgraWrData, eWd[cyc]);
      end
      checkOutput("cgra_rd_en", {31'd0, cgraRdEn}, {31'd0, eRd[cyc]});
      if (eRd[cyc]) checkOutput("cgra_rd_addr", cgraRdAddr, eRa[cyc]);
      checkOutput("rd_valid", {31'd0, glbRdValid}, {31'd0, eVal[cyc]});
      checkOutput("rd_data", glbRdData, expRdata);
      checkOutput("busy", {31'd0, glbBusy}, {31'd0, eBusy[cyc] != 0});
      checkOutput("err_collision", {31'd0, errCollision}, {31'd0, expErr});
      checkOutput("wr_count", {16'd0, wrCount}, 32'(expCnt));
      checkOutput("wr_count4", {28'd0, wrCount4}, 32'(expCnt4));

      if (rst) begin
         for (int k = cyc + 1; k <= cyc + L + 2; k++) begin
            eWr[k] = 0; eRd[k] = 0; eVal[k] = 0; eBusy[k] = 0;
         end
         expRdata = '0; expErr = 1'b0; expCnt = 0; expCnt4 = 0;
      end else begin
         if (eWr[cyc]) begin
            if (expCnt < 65535) expCnt++;
            if (expCnt4 < 15) expCnt4++;
         end
         if (wr && rd) expErr = 1'b1;
         else if (clr) expErr = 1'b0;
         if (wr && !rd) begin
            eWr[cyc+P] = 1; eWa[cyc+P] = addr; eWd[cyc+P] = data;
         end
         if (rd && !wr) begin
            eRd[cyc+P] = 1; eRa[cyc+P] = addr;
            eVal[cyc+L+1] = 1; eDat[cyc+L+1] = addr ^ MAGIC;
            for (int k = 1; k <= L; k++) eBusy[cyc+k]++;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0);
   endtask

   initial begin
      glbWrEn = 0; glbRdEn = 0; glbAddr = '0; glbWrData = '0; errClr = 0; reset = 1;
      @(posedge clk); #1;
      applyStimulus(0, 0, '0, '0, 0, 1);
      idle(2);

      applyStimulus(1, 0, 32'h0001_0203, 32'hDEADBEEF, 0, 0);
      idle(5);

      applyStimulus(0, 1, 32'h10, '0, 0, 0);
      idle(6);
      checkOutput("rd_hold_direct", glbRdData, 32'hA5A5A5B5);

      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'(i * 4), '0, 0, 0);
      idle(6);

      applyStimulus(1, 1, 32'h20, 32'h1234, 0, 0);
      idle(4);
      applyStimulus(0, 0, '0, '0, 1, 0);
      idle(2);
      applyStimulus(1, 1, 32'h24, 32'h5678, 1, 0);
      idle(2);
      applyStimulus(0, 0, '0, '0, 1, 0);
      idle(1);

      applyStimulus(0, 1, 32'h30, '0, 0, 0);
      idle(1);
      applyStimulus(0, 0, '0, '0, 0, 1);
      idle(4);
      applyStimulus(1, 0, 32'h40, 32'hCAFE, 0, 0);
      applyStimulus(0, 0, '0, '0, 0, 1);
      idle(4);

      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 32'(i), 32'(i * 3), 0, 0);
      idle(4);
      checkOutput("wr_count4_sat", {28'd0, wrCount4}, 32'd15);

      for (int i = 0; i < 500; i++) begin
         int r;
         logic w, rd;
         r  = $urandom_range(0, 99);
         w  = (r < 35) || (r >= 90 && r < 94);
         rd = (r >= 35 && r < 70) || (r >= 90 && r < 94);
         applyStimulus(w, rd, $urandom, $urandom, $urandom_range(0, 9) == 0, r == 99);
      end
      idle(L + 2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/glb_cgra_cfg_bridge.md
Name: glb_cgra_cfg_bridge

Overview:
- Per-PRR configuration bridge between one GLB tile's cgra_cfg_g2f port and one PRR's cfg_wr/cfg_rd port; one instance per PRR.
- Retimes config writes and reads across the GLB-to-CGRA boundary through a parameterised register pipeline.
- Matches read-back latency and returns read data to the GLB with a valid pulse.
- Flags illegal simultaneous read/write requests and counts forwarded writes for debug.

Parameters:
- ADDR_WIDTH, 32, config address width (CGRA_CFG_ADDR_WIDTH)
- DATA_WIDTH, 32, config data width (CGRA_CFG_DATA_WIDTH)
- PIPE_DEPTH, 2, forward register stages, legal range 1..4
- RD_LATENCY, 1, cycles from cgra_cfg_rd_en at the PRR to valid cgra_cfg_rd_data, legal range 0..3
- CNT_WIDTH, 16, width of the write counter

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- glb_cfg_wr_en  input  1  write request from GLB
- glb_cfg_rd_en  input  1  read request from GLB
- glb_cfg_addr  input  ADDR_WIDTH  request address
- glb_cfg_wr_data  input  DATA_WIDTH  write data
- glb_cfg_rd_data  output  DATA_WIDTH  returned read data
- glb_cfg_rd_data_valid  output  1  one-cycle pulse per completed read
- glb_cfg_busy  output  1  high while any read is in flight
- cgra_cfg_wr_en  output  1  write enable to PRR
- cgra_cfg_wr_addr  output  ADDR_WIDTH  write address to PRR
- cgra_cfg_wr_data  output  DATA_WIDTH  write data to PRR
- cgra_cfg_rd_en  output  1  read enable to PRR
- cgra_cfg_rd_addr  output  ADDR_WIDTH  read address to PRR
- cgra_cfg_rd_data  input  DATA_WIDTH  read data from PRR
- err_clr  input  1  clears err_collision
- err_collision  output  1  sticky collision flag
- wr_count  output  CNT_WIDTH  saturating count of forwarded writes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0. All pipeline stages, in-flight read tags and rd_data holding register cleared.
- Cycle convention: a request presented in cycle t is sampled at the end of cycle t.
- Forward path, write: wr_en only in cycle t drives cgra_cfg_wr_en=1 in cycle t+PIPE_DEPTH for exactly one cycle, with addr/data as sampled.
- Forward path, read: rd_en only in cycle t drives cgra_cfg_rd_en=1 with cgra_cfg_rd_addr in cycle t+PIPE_DEPTH.
- Enables are 0 in all other cycles. Addr/data stages load only on a valid request and otherwise hold.
- Throughput: one request per cycle; back-to-back requests of any mix are preserved in order.
- Collision: wr_en and rd_en both high in one cycle drops both requests; nothing is forwarded and no tag is created. err_collision is set the next cycle.
- err_collision clearing: stays high until err_clr. If err_clr and a new collision occur in the same cycle, set wins.
- Read return: a tag shift register of length PIPE_DEPTH+RD_LATENCY tracks reads.
- When a tag reaches the end of the tag register (cycle t+PIPE_DEPTH+RD_LATENCY), cgra_cfg_rd_data is captured.
- glb_cfg_rd_data_valid=1 in cycle t+PIPE_DEPTH+RD_LATENCY+1 with glb_cfg_rd_data equal to the captured value.
- glb_cfg_rd_data holds the last captured value until the next capture.
- Busy: glb_cfg_busy=1 whenever any tag bit is set, i.e. cycles t+1 through t+PIPE_DEPTH+RD_LATENCY. It falls in the valid-pulse cycle unless another read is in flight.
- Write counter: wr_count increments by 1 in the cycle a write is forwarded to the PRR, and saturates at 2^CNT_WIDTH-1 with no wrap.
- Reset mid-operation: all in-flight requests are discarded; no enables, no valid pulse and no count increment result from them.
- glb_cfg_busy and glb_cfg_rd_data_valid are 0 in the cycle after reset is asserted.
- Reads are not gated by busy: the GLB may issue a read while earlier reads are in flight.

Test Plan (PIPE_DEPTH=2, RD_LATENCY=1 unless noted; PRR model returns addr^32'hA5A5A5A5 RD_LATENCY cycles after rd_en):
- Write addr 32'h0001_0203, data 32'hDEADBEEF in cycle 0 -> cgra_cfg_wr_en=1 only in cycle 2 with those values; wr_count=1 from cycle 3; no read valid.
- Read addr 32'h10 in cycle 0 -> cgra_cfg_rd_en in cycle 2; glb_cfg_rd_data_valid only in cycle 4 with 32'hA5A5A5B5; busy=1 in cycles 1–3; rd_data holds A5A5A5B5 afterwards.
- Reads to 0x0,0x4,0x8,0xC in cycles 0–3 -> valid pulses in cycles 4–7 with A5A5A5A5, A5A5A5A1, A5A5A5AD, A5A5A5A9 in order; busy stays 1 in cycles 1–6.
- wr_en=rd_en=1 in cycle 0 -> no PRR enables; err_collision=1 from cycle 1; err_clr in cycle 5 clears it in cycle 6; collision with err_clr in the same cycle keeps it 1.
- Read in cycle 0, reset in cycle 2 -> no glb_cfg_rd_data_valid ever; busy=0 from cycle 3. Likewise a write in cycle 0 with reset in cycle 1 -> no cgra_cfg_wr_en and wr_count=0.
- CNT_WIDTH=4, 20 back-to-back writes -> wr_count reaches 15 and stays 15; all 20 cgra_cfg_wr_en pulses are still forwarded.
